cu_vertex_cache_control: RTL and testbench
==========================================

CU_VERTEX_CACHE_CONTROL -- requirements
Module: cu_vertex_cache_control

Interface
REQ-001 SHALL have parameter ADDR_W, 32: cacheline address width.
REQ-002 SHALL have parameter INDEX_W, 6: line-index width; 2^INDEX_W direct-mapped lines.
REQ-003 SHALL have parameter DATA_W, 512: cacheline data width.
REQ-004 SHALL have parameter ID_W, 8: request tag-id width.
REQ-005 SHALL have port clock  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rstn_in  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enabled_in  in  1  block enable.
REQ-008 SHALL have port flush_in  in  1  invalidate-all request, level-sampled.
REQ-009 SHALL have ports req_valid in 1, req_ready out 1, req_addr in ADDR_W, req_id in ID_W: vertex-line lookup request.
REQ-010 SHALL have ports rsp_valid out 1, rsp_data out DATA_W, rsp_id out ID_W, rsp_hit out 1, rsp_error out 1: lookup response; no backpressure.
REQ-011 SHALL have ports mem_cmd_valid out 1, mem_cmd_ready in 1, mem_cmd_addr out ADDR_W: miss read command.
REQ-012 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in DATA_W, mem_rsp_error in 1: miss read return.
REQ-013 SHALL have ports hit_count out 32, miss_count out 32: statistics.

Function
REQ-014 SHALL split address: index = req_addr[INDEX_W-1:0], tag = req_addr[ADDR_W-1:INDEX_W].
REQ-015 SHALL hold per-line valid bits in flops, tag and data in internal RAM with 1-cycle synchronous read.
REQ-016 SHALL implement FSM states IDLE, LOOKUP, MISS_ISSUE, MISS_WAIT, RESPOND.
REQ-017 SHALL drive req_ready=1 only in IDLE with enabled_in=1 and no flush pending that cycle.
REQ-018 IDLE: on req_valid&&req_ready, latch addr/id, issue RAM read at index, go to LOOKUP.
REQ-019 LOOKUP: hit = valid[index] && stored tag==latched tag; hit -> RESPOND with RAM data, rsp_hit=1, hit_count+1; miss -> MISS_ISSUE, miss_count+1.
REQ-020 MISS_ISSUE: mem_cmd_valid=1, mem_cmd_addr=latched addr, held stable until mem_cmd_ready; on handshake -> MISS_WAIT.
REQ-021 MISS_WAIT: on mem_rsp_valid with error=0, write tag/data at index, set valid[index], go to RESPOND with mem data, rsp_hit=0.
REQ-022 MISS_WAIT: on mem_rsp_valid with error=1, no fill, valid[index] unchanged, RESPOND with rsp_error=1, rsp_data=0.
REQ-023 RESPOND: rsp_valid=1 for exactly one cycle with registered data/id/hit/error, then IDLE.
REQ-024 Latency: hit rsp_valid exactly 3 cycles after accept edge; miss rsp_valid 1 cycle after mem_rsp_valid cycle.
REQ-025 SHALL ignore mem_rsp_valid outside MISS_WAIT; only one miss outstanding.
REQ-026 flush_in=1 in IDLE clears all valid bits in one cycle; req_ready=0 that cycle (flush wins over request).
REQ-027 flush_in during non-IDLE states SHALL set flush_pending; flush executes on first IDLE cycle, before any new accept; in-flight fill still completes first.
REQ-028 enabled_in=0 SHALL only block new accepts; in-flight transaction completes normally.
REQ-029 Counters SHALL saturate at 32'hFFFF_FFFF; flush does not clear them.
REQ-030 rsp_* payload SHALL hold last value when rsp_valid=0.

Reset
REQ-031 On rstn_in low: state=IDLE, all valid bits 0, flush_pending=0, counters 0, all outputs 0 (req_ready, rsp_*, mem_cmd_*).
REQ-032 Reset mid-miss SHALL abandon the transaction; a later mem_rsp_valid is ignored (IDLE).
REQ-033 RAM contents need not be reset; valid bits alone gate hits.

Verification
REQ-034 Cold miss: addr 0x0000_0041, id 5, mem_cmd_ready=1, mem_rsp data D1 after 4 cycles -> one mem_cmd at 0x41, rsp_hit=0, rsp_data=D1, rsp_id=5, miss_count=1.
REQ-035 Re-hit: repeat addr 0x41 id 6 -> no mem_cmd, rsp_valid 3 cycles after accept, rsp_hit=1, data D1, hit_count=1.
REQ-036 Conflict: addr 0x81 (same index 1, new tag) -> miss, fill D2; then 0x41 -> miss again (evicted).
REQ-037 Error return: miss with mem_rsp_error=1 -> rsp_error=1, rsp_data=0; same addr next -> miss again.
REQ-038 Flush during MISS_WAIT: fill completes, response issued, flush then clears all; following 0x41 lookup -> miss.
REQ-039 Backpressure/saturation: mem_cmd_ready low 10 cycles -> addr stable, mem_cmd_valid held; preload hit_count near max -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cu_vertex_cache_control.sv
// Direct-mapped vertex cacheline cache controller.
// One lookup in flight; misses go to memory one at a time.
module cu_vertex_cache_control #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 8
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  logic              flush_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_hit,
  output logic              rsp_error,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_error,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_ISSUE,
    S_MISS_WAIT,
    S_RESPOND
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic [LINES-1:0]  r_valid;
  logic              r_flush_pending;
  logic              r_cmp_done;
  logic              r_tag_eq;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_hit;
  logic              r_rsp_error;

  logic [TAG_W-1:0]  r_tag_mem [LINES];
  logic [DATA_W-1:0] r_data_mem [LINES];
  logic [TAG_W-1:0]  r_rd_tag;
  logic [DATA_W-1:0] r_rd_data;

  logic [INDEX_W-1:0] w_req_idx;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_accept;
  logic               w_fill;
  logic               w_flush_now;
  logic               w_hit_done;
  logic               w_miss_done;
  logic               w_mem_ret;

  assign w_req_idx = req_addr[INDEX_W-1:0];
  assign w_idx     = r_addr[INDEX_W-1:0];
  assign w_tag     = r_addr[ADDR_W-1:INDEX_W];

  // Held low during reset; a flush (new or deferred) beats any request.
  assign req_ready = rstn_in && (r_state == S_IDLE) && enabled_in
                     && !flush_in && !r_flush_pending;

  assign w_accept    = req_valid && req_ready;
  assign w_flush_now = (r_state == S_IDLE) && (flush_in || r_flush_pending);
  assign w_hit_done  = (r_state == S_LOOKUP) && r_cmp_done && r_tag_eq;
  assign w_miss_done = (r_state == S_LOOKUP) && r_cmp_done && !r_tag_eq;
  assign w_mem_ret   = (r_state == S_MISS_WAIT) && mem_rsp_valid;
  assign w_fill      = w_mem_ret && !mem_rsp_error;

  assign rsp_valid     = (r_state == S_RESPOND);
  assign rsp_data      = r_rsp_data;
  assign rsp_id        = r_rsp_id;
  assign rsp_hit       = r_rsp_hit;
  assign rsp_error     = r_rsp_error;
  assign mem_cmd_valid = (r_state == S_MISS_ISSUE);
  assign mem_cmd_addr  = r_addr;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

  // Next-state decode; LOOKUP spends one cycle registering the tag compare.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:       if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (r_cmp_done) w_next = r_tag_eq ? S_RESPOND : S_MISS_ISSUE;
      end
      S_MISS_ISSUE: if (mem_cmd_ready) w_next = S_MISS_WAIT;
      S_MISS_WAIT:  if (mem_rsp_valid) w_next = S_RESPOND;
      S_RESPOND:    w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Tag/data RAM: synchronous read on accept, write on a clean fill.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_rd_tag  <= r_tag_mem[w_req_idx];
      r_rd_data <= r_data_mem[w_req_idx];
    end
    if (w_fill) begin
      r_tag_mem[w_idx]  <= w_tag;
      r_data_mem[w_idx] <= mem_rsp_data;
    end
  end

  // Control state, valid bits, flush tracking, counters and response payload.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_id            <= '0;
      r_valid         <= '0;
      r_flush_pending <= 1'b0;
      r_cmp_done      <= 1'b0;
      r_tag_eq        <= 1'b0;
      r_hit_count     <= '0;
      r_miss_count    <= '0;
      r_rsp_data      <= '0;
      r_rsp_id        <= '0;
      r_rsp_hit       <= 1'b0;
      r_rsp_error     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cmp_done <= (r_state == S_LOOKUP) && !r_cmp_done;
      if (w_accept) begin
        r_addr <= req_addr;
        r_id   <= req_id;
      end
      if ((r_state == S_LOOKUP) && !r_cmp_done)
        r_tag_eq <= r_valid[w_idx] && (r_rd_tag == w_tag);
      if (r_state == S_IDLE)
        r_flush_pending <= 1'b0;
      else if (flush_in)
        r_flush_pending <= 1'b1;
      if (w_flush_now)
        r_valid <= '0;
      else if (w_fill)
        r_valid[w_idx] <= 1'b1;
      if (w_hit_done && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;
      if (w_miss_done && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
      if (w_hit_done) begin
        r_rsp_data  <= r_rd_data;
        r_rsp_id    <= r_id;
        r_rsp_hit   <= 1'b1;
        r_rsp_error <= 1'b0;
      end else if (w_mem_ret) begin
        r_rsp_data  <= mem_rsp_error ? '0 : mem_rsp_data;
        r_rsp_id    <= r_id;
        r_rsp_hit   <= 1'b0;
        r_rsp_error <= mem_rsp_error;
      end
    end
  end

endmodule

// File: tb/tb_cu_vertex_cache_control.sv
// Directed bench for cu_vertex_cache_control.
// Expected responses are queued at request time and popped on rsp_valid.
module tb_cu_vertex_cache_control;

  logic         clock = 1'b0;
  logic         rstn_in, enabled_in, flush_in;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic [7:0]   req_id;
  logic         rsp_valid, rsp_hit, rsp_error;
  logic [511:0] rsp_data;
  logic [7:0]   rsp_id;
  logic         mem_cmd_valid, mem_cmd_ready;
  logic [31:0]  mem_cmd_addr;
  logic         mem_rsp_valid, mem_rsp_error;
  logic [511:0] mem_rsp_data;
  logic [31:0]  hit_count, miss_count;

  typedef struct {
    logic [7:0]   id;
    logic [511:0] data;
    logic         hit;
    logic         err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          cmd_cnt = 0;
  int          acc_cyc = 0;
  int          mrsp_cyc = 0;
  logic [31:0] exp_hits = 32'd0;
  logic [31:0] exp_miss = 32'd0;
  logic [511:0] d1, d2, d3, d4, d5;

  cu_vertex_cache_control dut (
    .clock        (clock),
    .rstn_in      (rstn_in),
    .enabled_in   (enabled_in),
    .flush_in     (flush_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_id       (req_id),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .rsp_hit      (rsp_hit),
    .rsp_error    (rsp_error),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_error(mem_rsp_error),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  always @(posedge clock)
    if (mem_cmd_valid && mem_cmd_ready) cmd_cnt = cmd_cnt + 1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check512(input string tag, input logic [511:0] obs,
                          input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [7:0] k);
    return {16{24'hC0DE00, k}} ^ {4{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};
  endfunction

  task automatic send(input logic [31:0] a, input logic [7:0] id,
                      input logic [511:0] d, input bit hit, input bit err,
                      input bit push);
    exp_t e;
    int n;
    if (push) begin
      e.id   = id;
      e.data = err ? '0 : d;
      e.hit  = hit;
      e.err  = err;
      sb.push_back(e);
      if (hit) begin
        if (exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 32'd1;
      end else begin
        if (exp_miss != 32'hFFFF_FFFF) exp_miss = exp_miss + 32'd1;
      end
    end
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = a;
    req_id    = id;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check1("req_accept", req_ready, 1'b1);
    acc_cyc = cyc;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] a, input logic [511:0] d,
                       input bit err, input int hold, input int dly,
                       input bit fl);
    int n;
    n = 0;
    @(negedge clock);
    while (!mem_cmd_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check1("cmd_valid", mem_cmd_valid, 1'b1);
    check32("cmd_addr", mem_cmd_addr, a);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check1("cmd_hold_valid", mem_cmd_valid, 1'b1);
      check32("cmd_hold_addr", mem_cmd_addr, a);
    end
    mem_cmd_ready = 1'b1;
    @(posedge clock);
    #1 mem_cmd_ready = 1'b0;
    if (fl) begin
      @(negedge clock);
      flush_in = 1'b1;
      @(posedge clock);
      #1 flush_in = 1'b0;
    end
    repeat (dly) @(negedge clock);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    mem_rsp_error = err;
    mrsp_cyc = cyc;
    @(posedge clock);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_error = 1'b0;
  endtask

  task automatic wait_rsp(input int lat, input int ref_cyc);
    exp_t e;
    int n;
    n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check1("rsp_valid", rsp_valid, 1'b1);
    if (rsp_valid) begin
      check32("rsp_latency", 32'(cyc - ref_cyc), 32'(lat));
      check1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check32("rsp_id", 32'(rsp_id), 32'(e.id));
        check512("rsp_data", rsp_data, e.data);
        check1("rsp_hit", rsp_hit, e.hit);
        check1("rsp_error", rsp_error, e.err);
        @(negedge clock);
        check1("rsp_one_cycle", rsp_valid, 1'b0);
        check512("rsp_hold", rsp_data, e.data);
      end
    end
    check32("hit_count", hit_count, exp_hits);
    check32("miss_count", miss_count, exp_miss);
  endtask

  task automatic miss(input logic [31:0] a, input logic [7:0] id,
                      input logic [511:0] d, input bit err);
    send(a, id, d, 1'b0, err, 1'b1);
    serve(a, d, err, 0, 2, 1'b0);
    wait_rsp(1, mrsp_cyc);
  endtask

  task automatic hit(input logic [31:0] a, input logic [7:0] id,
                     input logic [511:0] d);
    send(a, id, d, 1'b1, 1'b0, 1'b1);
    wait_rsp(3, acc_cyc);
  endtask

  initial begin
    int n;
    d1 = pat(8'hD1);
    d2 = pat(8'hD2);
    d3 = pat(8'hD3);
    d4 = pat(8'hD4);
    d5 = pat(8'hD5);
    rstn_in       = 1'b0;
    enabled_in    = 1'b1;
    flush_in      = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_id        = '0;
    mem_cmd_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_error = 1'b0;
    mem_rsp_data  = '0;

    repeat (3) @(negedge clock);
    check1("rst_req_ready", req_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check512("rst_rsp_data", rsp_data, '0);
    check1("rst_cmd_valid", mem_cmd_valid, 1'b0);
    check32("rst_cmd_addr", mem_cmd_addr, 32'd0);
    check32("rst_hits", hit_count, 32'd0);
    check32("rst_misses", miss_count, 32'd0);
    rstn_in = 1'b1;
    @(negedge clock);
    check1("idle_ready", req_ready, 1'b1);

    // cold miss, then re-hit with no memory traffic
    send(32'h41, 8'd5, d1, 1'b0, 1'b0, 1'b1);
    serve(32'h41, d1, 1'b0, 0, 4, 1'b0);
    wait_rsp(1, mrsp_cyc);
    check32("cmd_cnt_cold", 32'(cmd_cnt), 32'd1);
    hit(32'h41, 8'd6, d1);
    check32("cmd_cnt_hit", 32'(cmd_cnt), 32'd1);

    // conflict eviction on index 1
    miss(32'h81, 8'd7, d2, 1'b0);
    hit(32'h81, 8'd8, d2);
    miss(32'h41, 8'd9, d3, 1'b0);

    // error return leaves the line invalid
    miss(32'h105, 8'd10, d5, 1'b1);
    miss(32'h105, 8'd11, d4, 1'b0);
    hit(32'h105, 8'd12, d4);

    // stray memory return while idle is ignored
    @(negedge clock);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d5;
    @(posedge clock);
    #1 mem_rsp_valid = 1'b0;
    @(negedge clock);
    check1("stray_no_rsp", rsp_valid, 1'b0);
    hit(32'h105, 8'd13, d4);

    // flush during MISS_WAIT: fill completes, then everything is dropped
    send(32'h22, 8'd14, d5, 1'b0, 1'b0, 1'b1);
    serve(32'h22, d5, 1'b0, 0, 2, 1'b1);
    wait_rsp(1, mrsp_cyc);
    check1("ready_flush_pending", req_ready, 1'b0);
    miss(32'h22, 8'd15, d5, 1'b0);
    miss(32'h41, 8'd16, d1, 1'b0);

    // flush in IDLE beats a simultaneous request
    @(negedge clock);
    flush_in  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h41;
    #1 check1("flush_blocks_ready", req_ready, 1'b0);
    @(posedge clock);
    #1;
    flush_in  = 1'b0;
    req_valid = 1'b0;
    miss(32'h41, 8'd17, d1, 1'b0);

    // disable blocks accepts but not the one in flight
    @(negedge clock);
    enabled_in = 1'b0;
    #1 check1("disabled_ready", req_ready, 1'b0);
    enabled_in = 1'b1;
    send(32'h41, 8'd18, d1, 1'b1, 1'b0, 1'b1);
    enabled_in = 1'b0;
    wait_rsp(3, acc_cyc);
    check1("disabled_after", req_ready, 1'b0);
    enabled_in = 1'b1;

    // memory command backpressure
    send(32'h3C0, 8'd19, d2, 1'b0, 1'b0, 1'b1);
    serve(32'h3C0, d2, 1'b0, 10, 1, 1'b0);
    wait_rsp(1, mrsp_cyc);

    // hit counter saturation
    @(negedge clock);
    force dut.r_hit_count = 32'hFFFF_FFFE;
    @(posedge clock);
    #1 release dut.r_hit_count;
    @(negedge clock);
    check32("hit_preload", hit_count, 32'hFFFF_FFFE);
    exp_hits = 32'hFFFF_FFFE;
    hit(32'h41, 8'd20, d1);
    hit(32'h3C0, 8'd21, d2);
    check32("hit_saturated", hit_count, 32'hFFFF_FFFF);

    // reset while a miss is outstanding
    send(32'h77, 8'd22, d3, 1'b0, 1'b0, 1'b0);
    n = 0;
    @(negedge clock);
    while (!mem_cmd_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check1("rm_cmd_valid", mem_cmd_valid, 1'b1);
    mem_cmd_ready = 1'b1;
    @(posedge clock);
    #1 mem_cmd_ready = 1'b0;
    @(negedge clock);
    rstn_in = 1'b0;
    #1;
    check1("rm_rsp_valid", rsp_valid, 1'b0);
    check32("rm_hits", hit_count, 32'd0);
    check32("rm_misses", miss_count, 32'd0);
    check1("rm_req_ready", req_ready, 1'b0);
    @(negedge clock);
    rstn_in = 1'b1;
    exp_hits = 32'd0;
    exp_miss = 32'd0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d3;
    @(posedge clock);
    #1 mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check1("rm_late_ignored", rsp_valid, 1'b0);
    end
    check1("rm_ready", req_ready, 1'b1);
    miss(32'h41, 8'd23, d1, 1'b0);

    check32("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
